// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and default sizing for the unified instruction/data memory arbiter.
package mem_arb_pkg;

  localparam int DEF_ADDR_W     = 32;
  localparam int DEF_DATA_W     = 32;
  localparam int DEF_LATENCY    = 2;
  localparam int DEF_STARVE_MAX = 4;

  typedef enum logic [1:0] {
    IDLE,
    I_BUSY,
    D_BUSY
  } arb_state_t;

  typedef enum logic {
    OWN_I,
    OWN_D
  } owner_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch port, data port and memory bus of the arbiter, bundled as one interface.
interface mem_port_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) ();

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_flush;
  logic [DATA_W-1:0] if_rdata;
  logic              if_valid;
  logic              if_stall;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_valid;
  logic              d_stall;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // pipeline requesters plus the memory macro
  modport master (
    output if_req, if_addr, if_flush,
    input  if_rdata, if_valid, if_stall,
    output d_req, d_we, d_addr, d_wdata,
    input  d_rdata, d_valid, d_stall,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

  // the arbiter itself
  modport slave (
    input  if_req, if_addr, if_flush,
    output if_rdata, if_valid, if_stall,
    input  d_req, d_we, d_addr, d_wdata,
    output d_rdata, d_valid, d_stall,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

endinterface

// File: rtl/mem_port_arbiter_lat_counter.sv
// Loadable down-counter: loaded in the mem_en cycle, done fires in the cycle mem_rdata is valid.
module arb_lat_counter #(
  parameter int LATENCY = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic done
);

  localparam int CNT_W = $clog2(LATENCY + 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CNT_W'(LATENCY);
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  // terminal count reached one cycle before the counter parks at zero
  assign done = (cnt == CNT_W'(1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter: data-first fixed priority with a bound on fetch starvation.
//
// state  | meaning
// IDLE   | no transaction in flight; grant evaluated every cycle
// I_BUSY | fetch in flight; a flush here marks the result to be dropped
// D_BUSY | load/store in flight; flush has no effect
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int LATENCY    = DEF_LATENCY,
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus
);

  localparam int SC_W = $clog2(STARVE_MAX + 1);

  arb_state_t      state;
  logic [SC_W-1:0] starve_cnt;
  logic            kill;
  logic            lat_done;
  logic            gnt;
  owner_t          gnt_own;

  arb_lat_counter #(
    .LATENCY (LATENCY)
  ) u_lat (
    .clk  (clk),
    .rst  (rst),
    .load (bus.mem_en),
    .done (lat_done)
  );

  always_comb begin
    gnt     = 1'b0;
    gnt_own = OWN_I;
    if (state == IDLE) begin
      if (bus.d_req && ((starve_cnt < SC_W'(STARVE_MAX)) || !bus.if_req)) begin
        gnt     = 1'b1;
        gnt_own = OWN_D;
      end else if (bus.if_req && !bus.if_flush) begin
        gnt     = 1'b1;
        gnt_own = OWN_I;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      starve_cnt    <= '0;
      kill          <= 1'b0;
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.if_valid  <= 1'b0;
      bus.if_rdata  <= '0;
      bus.d_valid   <= 1'b0;
      bus.d_rdata   <= '0;
    end else begin
      bus.mem_en   <= 1'b0;
      bus.if_valid <= 1'b0;
      bus.d_valid  <= 1'b0;
      case (state)
        IDLE: begin
          if (gnt) begin
            bus.mem_en <= 1'b1;
            if (gnt_own == OWN_D) begin
              state         <= D_BUSY;
              bus.mem_we    <= bus.d_we;
              bus.mem_addr  <= bus.d_addr;
              bus.mem_wdata <= bus.d_wdata;
              if (!bus.if_req) begin
                starve_cnt <= '0;
              end else if (starve_cnt != SC_W'(STARVE_MAX)) begin
                starve_cnt <= starve_cnt + 1'b1;
              end
            end else begin
              state        <= I_BUSY;
              bus.mem_we   <= 1'b0;
              bus.mem_addr <= bus.if_addr;
              starve_cnt   <= '0;
            end
          end
        end
        I_BUSY: begin
          if (bus.if_flush) begin
            kill <= 1'b1;
          end
          if (lat_done) begin
            state <= IDLE;
            kill  <= 1'b0;
            // a flush in the sampling cycle itself also drops the fetch
            if (!kill && !bus.if_flush) begin
              bus.if_valid <= 1'b1;
              bus.if_rdata <= bus.mem_rdata;
            end
          end
        end
        D_BUSY: begin
          if (lat_done) begin
            state       <= IDLE;
            bus.d_valid <= 1'b1;
            if (!bus.mem_we) begin
              bus.d_rdata <= bus.mem_rdata;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // gated by reset so every output reads zero while rst is held low
  assign bus.if_stall = rst & bus.if_req & ~bus.if_valid;
  assign bus.d_stall  = rst & bus.d_req & ~bus.d_valid;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one single-port unified instruction/data memory between the IF stage (read-only fetch) and the MEM stage (load/store). It uses fixed priority with data first, plus a bound on instruction starvation. A fixed-latency counter sequences each memory transaction. Per-requester stall outputs feed the pipeline hold logic (hold_pc/hold_if, MEM-stage freeze).

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
LATENCY, 2, cycles from mem_en cycle to mem_rdata valid (legal values are 1 or more)
STARVE_MAX, 4, max consecutive data grants while if_req is pending

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
if_req  in  1  fetch request, held with if_addr until if_valid
if_addr  in  ADDR_W  fetch address
if_flush  in  1  cancel pending fetch (branch/jump/exception)
if_rdata  out  DATA_W  fetched instruction
if_valid  out  1  one-cycle completion pulse for fetch
if_stall  out  1  if_req & ~if_valid
d_req  in  1  data request, held until d_valid
d_we  in  1  1 = store, 0 = load
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_rdata  out  DATA_W  load data
d_valid  out  1  one-cycle completion pulse for load/store
d_stall  out  1  d_req & ~d_valid
mem_en  out  1  memory access strobe, one cycle per transaction
mem_we  out  1  memory write enable, qualified by mem_en
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid LATENCY cycles after the mem_en cycle

Behaviour:
- Reset (rst=0, async): state IDLE; starve_cnt=0; kill=0; latency counter=0.
- Reset values of all outputs: 0, including if_rdata, d_rdata and the mem_* bus.
- FSM has three states: IDLE, I_BUSY, D_BUSY.
- IDLE grant rule, evaluated each cycle:
  - Data is granted if d_req & (starve_cnt<STARVE_MAX | ~if_req).
  - Otherwise fetch is granted if if_req & ~if_flush.
  - Otherwise the FSM stays in IDLE.
- On grant, the request fields are latched at the edge; state moves to the matching BUSY state.
- Timing per transaction (cycle 0 = accept cycle in IDLE):
  - Cycle 1: mem_en=1 and mem_addr/mem_we/mem_wdata are registered values. mem_we=0 for fetches.
  - Cycle 1+LATENCY: mem_rdata is sampled at the end of the cycle.
  - Cycle 2+LATENCY: x_valid=1 and x_rdata is updated; state is IDLE, so a new grant can be accepted in this same cycle.
- Throughput: one transaction per LATENCY+2 cycles.
- mem_en is 0 outside cycle 1; the mem_* bus holds its last value.
- Stores: same timing. d_valid pulses. d_rdata is unchanged.
- Rdata outputs hold their value between completions.
- Starvation counter:
  - A data grant with if_req=1 increments starve_cnt, saturating at STARVE_MAX.
  - A data grant with if_req=0, or any fetch grant, clears it to 0.
  - When starve_cnt==STARVE_MAX with both requests pending, the fetch wins.
- Flush:
  - if_flush in IDLE blocks a fetch grant that cycle.
  - if_flush during I_BUSY sets kill. The memory read still completes with no abort. if_valid is suppressed and if_rdata is not updated. kill clears on return to IDLE.
  - if_flush has no effect in D_BUSY.
- Simultaneous completion and new request: the valid pulse and the IDLE grant happen in the same cycle.
- The requester must drop req or change addr only after valid. The arbiter does not check this; behaviour on early withdrawal is undefined.
- Reset mid-transaction: the transaction is dropped and no valid pulse is produced. A store whose mem_en cycle has already passed is committed in memory.

Decomposition:
- Package mem_arb_pkg holds:
  - state enum arb_state_t {IDLE, I_BUSY, D_BUSY};
  - owner enum {OWN_I, OWN_D};
  - default width constants.
- One sub-module, arb_lat_counter: a loadable down-counter with a done pulse.
  - Loaded with LATENCY on issue; done fires in cycle 1+LATENCY.
  - Async active-low reset.
- Grant logic and FSM stay in the top module.

Test Plan:
- Only if_req, addr 0x10, mem returns 0x2402000A, LATENCY=2:
  - mem_en at cycle 1 with mem_addr=0x10, mem_we=0.
  - if_valid=1 and if_rdata=0x2402000A at cycle 4.
  - if_stall=1 in cycles 0-3.
- if_req and d_req (store, addr 0x08, data 0x55) asserted together:
  - Data is served first; mem_we=1, mem_wdata=0x55 at cycle 1.
  - d_valid at cycle 4; fetch accepted at cycle 4, mem_en at cycle 5, if_valid at cycle 8.
- Continuous d_req plus continuous if_req, STARVE_MAX=4:
  - Grant order is D,D,D,D,I,D,…
  - starve_cnt reaches 4, then clears to 0 after the fetch grant.
- Fetch accepted, if_flush=1 at cycle 2:
  - mem_en still pulses at cycle 1.
  - No if_valid at cycle 4; if_rdata keeps its old value.
  - A new fetch is accepted in cycle 4 if requested.
- rst driven low asynchronously at cycle 2 of a load:
  - All outputs 0 immediately; state IDLE; no d_valid.
  - After release, a re-issued load completes normally in LATENCY+2 cycles.
